// File: rtl/aftab_addsub_arbiter_pkg.sv
// Shared types and helpers for the AFTAB adder/subtractor arbiter.
package aftab_addsub_arbiter_pkg;

    // Sequencer states: pick a winner, run the shared adder, present the result
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } arb_state_t;

    // Width of a binary requester index (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aftab_addsub_arbiter_if.sv
// Requester-side bus of the shared adder/subtractor arbiter.
// Requester i owns slice [i*size +: size] of aBus/bBus and bit i of the
// per-requester control vectors.
interface aftab_addsub_arbiter_if #(
    parameter int size   = 32,
    parameter int numReq = 3
);
    logic [numReq-1:0]      req;
    logic [numReq*size-1:0] aBus;
    logic [numReq*size-1:0] bBus;
    logic [numReq-1:0]      subselBus;
    logic [numReq-1:0]      passBus;
    logic [numReq-1:0]      grant;
    logic [numReq-1:0]      done;
    logic [size-1:0]        result;
    logic                   cout;
    logic                   busy;

    modport master (
        output req, aBus, bBus, subselBus, passBus,
        input  grant, done, result, cout, busy
    );

    modport slave (
        input  req, aBus, bBus, subselBus, passBus,
        output grant, done, result, cout, busy
    );
endinterface

// File: rtl/aftab_adder_subtractor.sv
// Shared adder/subtractor. pass forwards b while the adder still forms a+b
// for the carry; otherwise subSel selects a + ~b + 1 (cout = NOT borrow).
module aftab_adder_subtractor #(
    parameter int size = 32
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            subSel,
    input  logic            pass,
    output logic [size-1:0] outRes,
    output logic            cout
);
    logic            cin;
    logic [size-1:0] b_eff;
    logic [size:0]   sum;

    // Single carry chain; pass forces plain addition for the carry output
    always_comb begin
        cin    = subSel & ~pass;
        b_eff  = cin ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{size{1'b0}}, cin};
        outRes = pass ? b : sum[size-1:0];
        cout   = sum[size];
    end
endmodule

// File: rtl/aftab_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from numReq-1 back to 0. Returns one-hot and binary forms.
module aftab_rr_picker #(
    parameter int numReq = 3,
    parameter int idxW   = 2
) (
    input  logic [numReq-1:0] req,
    input  logic [idxW-1:0]   ptr,
    output logic [numReq-1:0] onehot,
    output logic [idxW-1:0]   idx,
    output logic              any
);

    // Scan numReq positions starting at ptr; the first hit wins
    always_comb begin : scan
        int              pos;
        logic [idxW-1:0] p;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        p      = '0;
        for (int k = 0; k < numReq; k++) begin
            pos = int'(ptr) + k;
            if (pos >= numReq) pos = pos - numReq;
            p = idxW'(pos);
            if (!any && req[p]) begin
                any       = 1'b1;
                onehot[p] = 1'b1;
                idx       = p;
            end
        end
    end

endmodule

// File: rtl/aftab_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one aftab_adder_subtractor among
// numReq requesters: IDLE picks and latches, CALC computes, DONE pulses.
// Optional macro AFTAB_ADDSUB_ARB_FASTPATH_EN lets DONE arbitrate the next
// request directly (masking the requester just served), giving one
// operation per 2 cycles instead of 3.
module aftab_addsub_arbiter
    import aftab_addsub_arbiter_pkg::*;
#(
    parameter int size   = 32,
    parameter int numReq = 3
) (
    input logic                   clk,
    input logic                   rst,
    aftab_addsub_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(numReq);

    arb_state_t        state;
    logic [numReq-1:0] grant_r;
    logic [numReq-1:0] done_r;
    logic [size-1:0]   result_r;
    logic              cout_r;
    logic              busy_r;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [size-1:0]   op_a;
    logic [size-1:0]   op_b;
    logic              op_sub;
    logic              op_pass;

    logic [numReq-1:0] pick_req;
    logic [IDX_W-1:0]  pick_ptr;
    logic [numReq-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  next_ptr;
    logic [size-1:0]   sel_a;
    logic [size-1:0]   sel_b;
    logic              sel_sub;
    logic              sel_pass;
    logic [size-1:0]   add_res;
    logic              add_cout;

    assign next_ptr = (win_idx == IDX_W'(numReq - 1)) ? '0 : win_idx + IDX_W'(1);

`ifdef AFTAB_ADDSUB_ARB_FASTPATH_EN
    // In DONE the served requester is masked and the pointer is already past it
    assign pick_req = (state == DONE) ? (bus.req & ~grant_r) : bus.req;
    assign pick_ptr = (state == DONE) ? next_ptr : rr_ptr;
`else
    assign pick_req = bus.req;
    assign pick_ptr = rr_ptr;
`endif

    aftab_rr_picker #(
        .numReq (numReq),
        .idxW   (IDX_W)
    ) u_picker (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Winner's operand slices, latched only on an arbitration cycle
    assign sel_a    = bus.aBus[int'(pick_idx)*size +: size];
    assign sel_b    = bus.bBus[int'(pick_idx)*size +: size];
    assign sel_sub  = bus.subselBus[pick_idx];
    assign sel_pass = bus.passBus[pick_idx];

    // Adder sees only the latched operands, never the live buses
    aftab_adder_subtractor #(
        .size   (size)
    ) u_addsub (
        .a      (op_a),
        .b      (op_b),
        .subSel (op_sub),
        .pass   (op_pass),
        .outRes (add_res),
        .cout   (add_cout)
    );

    // Sequencer FSM with registered grant/done/result/busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_r  <= '0;
            done_r   <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            busy_r   <= 1'b0;
            rr_ptr   <= '0;
            win_idx  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            op_pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= '0;
                    if (pick_any) begin
                        win_idx <= pick_idx;
                        grant_r <= pick_onehot;
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_sub  <= sel_sub;
                        op_pass <= sel_pass;
                        busy_r  <= 1'b1;
                        state   <= CALC;
                    end else begin
                        grant_r <= '0;
                    end
                end
                CALC: begin
                    result_r <= add_res;
                    cout_r   <= add_cout;
                    done_r   <= grant_r;
                    state    <= DONE;
                end
                DONE: begin
                    done_r <= '0;
                    rr_ptr <= next_ptr;
`ifdef AFTAB_ADDSUB_ARB_FASTPATH_EN
                    if (pick_any) begin
                        win_idx <= pick_idx;
                        grant_r <= pick_onehot;
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_sub  <= sel_sub;
                        op_pass <= sel_pass;
                        state   <= CALC;
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
`else
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
`endif
                end
                default: begin
                    grant_r <= '0;
                    done_r  <= '0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant  = grant_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_aftab_addsub_arbiter.sv
// Self-checking bench for aftab_addsub_arbiter (size=32, numReq=3) with a
// behavioural reference model of arbitration order and arithmetic.
module tb_aftab_addsub_arbiter;
    localparam int W = 32;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aftab_addsub_arbiter_if #(.size(W), .numReq(N)) bus ();

    aftab_addsub_arbiter #(.size(W), .numReq(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int mdl_ptr = 0;
    logic [W-1:0] ta [N];
    logic [W-1:0] tb_ [N];
    logic         ts [N];
    logic         tp [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting index at or after ptr, cyclically
    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Reference arithmetic, returns {cout, result}
    function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic pass);
        logic [W:0] s;
        logic [W-1:0] nb;
        if (pass) begin
            s = {1'b0, a} + {1'b0, b};
            return {s[W], b};
        end
        if (sub) begin
            nb = ~b;
            return {1'b0, a} + {1'b0, nb} + 33'd1;
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic pass);
        ta[i] = a; tb_[i] = b; ts[i] = sub; tp[i] = pass;
        bus.aBus[i*W +: W] = a;
        bus.bBus[i*W +: W] = b;
        bus.subselBus[i]   = sub;
        bus.passBus[i]     = pass;
    endtask

    // One transaction from IDLE; optionally disturb winner's a after grant
    task automatic run_one(input logic [N-1:0] r, input bit disturb,
                           input logic [W-1:0] new_a, input string tag);
        int w;
        int cyc;
        logic [W:0] e;
        w = ref_pick(r, mdl_ptr);
        e = ref_calc(ta[w], tb_[w], ts[w], tp[w]);
        bus.req = r;
        @(negedge clk);
        check({tag, ".grant"}, 64'(bus.grant), 64'(1 << w));
        check({tag, ".busy"},  64'(bus.busy),  64'd1);
        if (disturb) bus.aBus[w*W +: W] = new_a;
        cyc = 1;
        while (bus.done == '0 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'd2);
        check({tag, ".done"},    64'(bus.done),   64'(1 << w));
        check({tag, ".result"},  64'(bus.result), 64'(e[W-1:0]));
        check({tag, ".cout"},    64'(bus.cout),   64'(e[W]));
        bus.req = '0;
        if (disturb) bus.aBus[w*W +: W] = ta[w];
        mdl_ptr = (w + 1) % N;
        @(negedge clk);
        check({tag, ".idle_done"}, 64'(bus.done),   64'd0);
        check({tag, ".idle_busy"}, 64'(bus.busy),   64'd0);
        check({tag, ".hold"},      64'(bus.result), 64'(e[W-1:0]));
    endtask

    initial begin
        int w, cyc, exp_gap;
        logic [W:0] e;
        logic [N-1:0] r;

        rst = 1'b1;
        bus.req = '0; bus.aBus = '0; bus.bBus = '0;
        bus.subselBus = '0; bus.passBus = '0;
        for (int i = 0; i < N; i++) set_op(i, '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst.grant",  64'(bus.grant),  64'd0);
        check("rst.done",   64'(bus.done),   64'd0);
        check("rst.result", 64'(bus.result), 64'd0);
        check("rst.cout",   64'(bus.cout),   64'd0);
        check("rst.busy",   64'(bus.busy),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        set_op(0, 32'h5, 32'h3, 1'b0, 1'b0);
        run_one(3'b001, 1'b0, '0, "add");
        set_op(1, 32'h3, 32'h5, 1'b1, 1'b0);
        run_one(3'b010, 1'b0, '0, "sub_borrow");
        set_op(1, 32'h5, 32'h3, 1'b1, 1'b0);
        run_one(3'b010, 1'b0, '0, "sub_noborrow");
        set_op(2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run_one(3'b100, 1'b0, '0, "pass");
        set_op(0, 32'h5, 32'h3, 1'b0, 1'b0);
        run_one(3'b001, 1'b1, 32'h9, "stable");

        // Sustained requests from all three: rotation and throughput
        set_op(0, 32'h10, 32'h1, 1'b0, 1'b0);
        set_op(1, 32'h20, 32'h2, 1'b1, 1'b0);
        set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        bus.req = 3'b111;
        for (int j = 0; j < 6; j++) begin
            w = ref_pick(3'b111, mdl_ptr);
            e = ref_calc(ta[w], tb_[w], ts[w], tp[w]);
`ifdef AFTAB_ADDSUB_ARB_FASTPATH_EN
            exp_gap = 2;
`else
            exp_gap = (j == 0) ? 2 : 3;
`endif
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (bus.done == '0 && cyc < 10);
            check("rr.gap",    64'(cyc),         64'(exp_gap));
            check("rr.done",   64'(bus.done),    64'(1 << w));
            check("rr.result", 64'(bus.result),  64'(e[W-1:0]));
            check("rr.cout",   64'(bus.cout),    64'(e[W]));
            mdl_ptr = (w + 1) % N;
        end
        bus.req = '0;
        @(negedge clk);
        check("rr.idle_busy", 64'(bus.busy), 64'd0);

        // Randomised transactions
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < N; i++)
                set_op(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'(i) : $urandom,
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            r = 3'($urandom_range(1, 7));
            run_one(r, 1'($urandom_range(0, 1)), $urandom, "rand");
        end

        // Leave pointer at 2, then abort an operation with reset
        set_op(1, 32'h7, 32'h8, 1'b0, 1'b0);
        run_one(3'b010, 1'b0, '0, "pre_rst");
        set_op(0, 32'h11, 32'h22, 1'b0, 1'b0);
        bus.req = 3'b001;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.grant",  64'(bus.grant),  64'd0);
        check("midrst.result", 64'(bus.result), 64'd0);
        check("midrst.cout",   64'(bus.cout),   64'd0);
        check("midrst.busy",   64'(bus.busy),   64'd0);
        bus.req = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("midrst.no_done", 64'(bus.done), 64'd0);
        end
        rst = 1'b0;
        mdl_ptr = 0;
        @(negedge clk);
        check("postrst.no_done", 64'(bus.done), 64'd0);
        set_op(1, 32'h40, 32'h2, 1'b0, 1'b0);
        set_op(2, 32'h80, 32'h3, 1'b0, 1'b0);
        run_one(3'b110, 1'b0, '0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
